// File: rtl/wb_regfile_sb_if.sv
// -----------------------------------------------------------------------------
// wb_regfile_sb_if
//   Groups the MEM/WB write-back signals and the ID read/issue signals that
//   connect to the write-back register file.
//   master : MEM/WB + ID side (drives write-back and read/issue requests)
//   slave  : register file (returns wdata, read data and busy flags)
// Signals
//   wmo, walu, wrn, wwreg, wm2reg : write-back from MEM/WB
//   wdata                         : selected write-back value (forwarding)
//   ra1, ra2 / rd1, rd2           : ID read addresses / data
//   busy1, busy2                  : pending-write flags for ra1 / ra2
//   iss_en, iss_rn                : ID issue of an instruction writing iss_rn
// -----------------------------------------------------------------------------
interface wb_regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [DATA_W-1:0] wmo;
    logic [DATA_W-1:0] walu;
    logic [ADDR_W-1:0] wrn;
    logic              wwreg;
    logic              wm2reg;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              busy1;
    logic              busy2;
    logic              iss_en;
    logic [ADDR_W-1:0] iss_rn;

    modport master (
        output wmo, walu, wrn, wwreg, wm2reg, ra1, ra2, iss_en, iss_rn,
        input  wdata, rd1, rd2, busy1, busy2
    );

    modport slave (
        input  wmo, walu, wrn, wwreg, wm2reg, ra1, ra2, iss_en, iss_rn,
        output wdata, rd1, rd2, busy1, busy2
    );
endinterface

// File: rtl/wb_regfile_sb.sv
// -----------------------------------------------------------------------------
// wb_regfile_sb
//   Write-back stage register file with pending-write scoreboard.
//   - Selects load data or ALU result and writes it to the register file.
//   - Two combinational read ports with same-cycle write-back bypass.
//   - One busy bit per register: set when ID issues a writer, cleared when
//     the result is written back. r0 reads 0 and is never busy.
// Ports
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset, clears registers and scoreboard
//   bus   : wb_regfile_sb_if.slave (write-back, read ports, issue, busy)
// -----------------------------------------------------------------------------
module wb_regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    wb_regfile_sb_if.slave   bus
);
    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;

    logic [DATA_W-1:0] wdata;
    logic              wr_en;
    logic              byp1;
    logic              byp2;
    logic              iss1;
    logic              iss2;

    // The select is independent of wwreg so the forwarding path is valid early.
    assign wdata = bus.wm2reg ? bus.wmo : bus.walu;
    assign wr_en = bus.wwreg && (bus.wrn != '0);

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_en) begin
            regs_d[bus.wrn] = wdata;
            busy_d[bus.wrn] = 1'b0;
        end
        // Issue is applied after write-back so a same-register set wins:
        // the issued instruction is younger than the one retiring.
        if (bus.iss_en && (bus.iss_rn != '0)) begin
            busy_d[bus.iss_rn] = 1'b1;
        end
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
    end

    // NOTE: the register array is reset explicitly because an asynchronous
    // reset must make every register read 0 immediately, which rules out
    // mapping it onto a plain RAM macro.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Read ports: r0 first, then bypass of the value being written, then array.
    assign byp1 = bus.wwreg && (bus.wrn == bus.ra1);
    assign byp2 = bus.wwreg && (bus.wrn == bus.ra2);
    assign iss1 = bus.iss_en && (bus.iss_rn == bus.ra1);
    assign iss2 = bus.iss_en && (bus.iss_rn == bus.ra2);

    assign bus.wdata = wdata;
    assign bus.rd1   = (bus.ra1 == '0) ? '0 : (byp1 ? wdata : regs_q[bus.ra1]);
    assign bus.rd2   = (bus.ra2 == '0) ? '0 : (byp2 ? wdata : regs_q[bus.ra2]);

    // A register being written this cycle is not busy to the reader, because
    // the bypass already delivers its value -- unless a younger writer to the
    // same register issues in the same cycle.
    assign bus.busy1 = (bus.ra1 != '0) && busy_q[bus.ra1] && !(byp1 && !iss1);
    assign bus.busy2 = (bus.ra2 != '0) && busy_q[bus.ra2] && !(byp2 && !iss2);

endmodule
